dmem_access_stage: RTL and testbench

- Pipeline MEM stage, directly downstream of the execute stage.
- Consumes the registered EX result, destination, writeback flag, store value and memory-read/memory-write flags.
- Performs word loads/stores over a req/ack data-memory port, stalling upstream while a memory access is outstanding.
- Registers ALU results or load data toward the writeback stage; flags misaligned accesses and bus timeouts.

---
 rtl/dmem_stage_pkg.sv | 17 +
 rtl/dmem_access_stage_if.sv | 27 ++
 rtl/dmem_timeout_ctr.sv | 37 +++
 rtl/dmem_access_stage.sv | 142 ++++++++++++++
 tb/tb_dmem_access_stage.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_stage_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : dmem_stage_pkg                                         |
// | Description : Shared state encoding and defaults for the MEM stage.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package dmem_stage_pkg;

   typedef enum logic [0:0] {
      ST_IDLE     = 1'b0,
      ST_WAIT_ACK = 1'b1
   } state_t;

   localparam int c_TIMEOUT_CYCLES = 16;

endpackage
`default_nettype wire

// File: rtl/dmem_access_stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : dmem_access_stage_if                                   |
// | Description : Data-memory req/ack port between MEM stage and memory. |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface dmem_access_stage_if;

   logic        MemReq;
   logic        MemWe;
   logic [31:0] MemAddr;
   logic [31:0] MemWData;
   logic        MemAck;
   logic [31:0] MemRData;

   modport master (
      output MemReq, MemWe, MemAddr, MemWData,
      input  MemAck, MemRData
   );

   modport slave (
      input  MemReq, MemWe, MemAddr, MemWData,
      output MemAck, MemRData
   );

endinterface
`default_nettype wire

// File: rtl/dmem_timeout_ctr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : dmem_timeout_ctr                                       |
// | Description : Clear/enable cycle counter with terminal-count flag.   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module dmem_timeout_ctr
   import dmem_stage_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = c_TIMEOUT_CYCLES,
   parameter int CNT_W          = 5
) (
   input  wire logic Clk,
   input  wire logic Reset,
   input  wire logic clr,
   input  wire logic en,
   output logic      expire_tc
);

   localparam logic [CNT_W-1:0] c_TC = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_count <= '0;
      end else if (clr) begin
         r_count <= '0;
      end else if (en) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign expire_tc = (r_count == c_TC);

endmodule
`default_nettype wire

// File: rtl/dmem_access_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : dmem_access_stage                                      |
// | Description : Pipeline MEM stage: word load/store over req/ack bus,  |
// |               ALU passthrough, alignment and bus-timeout errors.     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module dmem_access_stage
   import dmem_stage_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = c_TIMEOUT_CYCLES,
   parameter int CNT_W          = 5
) (
   input  wire logic               Clk,
   input  wire logic               Reset,
   input  wire logic [31:0]        ExResult,
   input  wire logic [4:0]         ExDst,
   input  wire logic               ExWriteBack,
   input  wire logic [31:0]        ExStoreVal,
   input  wire logic               ExMemRead,
   input  wire logic               ExMemWrite,
   output logic                    Stall,
   dmem_access_stage_if.master     mem,
   output logic [31:0]             WbResult,
   output logic [4:0]              WbDst,
   output logic                    WbWriteBack,
   output logic                    AlignErr,
   output logic                    BusErr
);

   state_t      r_state;
   logic [31:0] r_wb_result;
   logic [4:0]  r_wb_dst;
   logic        r_wb_we;
   logic        r_align_err;
   logic        r_bus_err;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic        r_we;
   logic [4:0]  r_dst;
   logic        r_wb_flag;

   logic w_memop;
   logic w_aligned;
   logic w_idle;
   logic w_wait;
   logic w_start;
   logic w_tc;
   logic w_expire;

   assign w_memop   = ExMemRead | ExMemWrite;
   assign w_aligned = (ExResult[1:0] == 2'b00);
   assign w_idle    = (r_state == ST_IDLE);
   assign w_wait    = (r_state == ST_WAIT_ACK);
   assign w_start   = w_idle & w_memop & w_aligned;
   assign w_expire  = w_wait & ~mem.MemAck & w_tc;

   dmem_timeout_ctr #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .CNT_W          (CNT_W)
   ) u_timeout_ctr (
      .Clk       (Clk),
      .Reset     (Reset),
      .clr       (w_start),
      .en        (w_wait & ~mem.MemAck),
      .expire_tc (w_tc)
   );

   // Gated by reset so upstream is never held while the stage is being reset.
   assign Stall = Reset & (w_start | (w_wait & ~mem.MemAck & ~w_expire));

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_state     <= ST_IDLE;
         r_wb_result <= '0;
         r_wb_dst    <= '0;
         r_wb_we     <= 1'b0;
         r_align_err <= 1'b0;
         r_bus_err   <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_we        <= 1'b0;
         r_dst       <= '0;
         r_wb_flag   <= 1'b0;
      end else begin
         r_align_err <= 1'b0;
         r_bus_err   <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (!w_memop) begin
                  r_wb_result <= ExResult;
                  r_wb_dst    <= ExDst;
                  r_wb_we     <= ExWriteBack & (ExDst != 5'd0);
               end else if (!w_aligned) begin
                  r_align_err <= 1'b1;
                  r_wb_we     <= 1'b0;
               end else begin
                  r_addr    <= ExResult;
                  r_wdata   <= ExStoreVal;
                  r_we      <= ExMemWrite;
                  r_dst     <= ExDst;
                  r_wb_flag <= ExWriteBack;
                  r_wb_we   <= 1'b0;
                  r_state   <= ST_WAIT_ACK;
               end
            end
            ST_WAIT_ACK: begin
               // Ack has priority over the terminal count in the same cycle.
               if (mem.MemAck) begin
                  if (!r_we) begin
                     r_wb_result <= mem.MemRData;
                     r_wb_dst    <= r_dst;
                     r_wb_we     <= r_wb_flag & (r_dst != 5'd0);
                  end else begin
                     r_wb_we <= 1'b0;
                  end
                  r_state <= ST_IDLE;
               end else if (w_tc) begin
                  r_bus_err <= 1'b1;
                  r_wb_we   <= 1'b0;
                  r_state   <= ST_IDLE;
               end else begin
                  r_wb_we <= 1'b0;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign mem.MemReq   = w_wait;
   assign mem.MemWe    = r_we;
   assign mem.MemAddr  = r_addr;
   assign mem.MemWData = r_wdata;
   assign WbResult     = r_wb_result;
   assign WbDst        = r_wb_dst;
   assign WbWriteBack  = r_wb_we;
   assign AlignErr     = r_align_err;
   assign BusErr       = r_bus_err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_access_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_dmem_access_stage                                   |
// | Description : Table-driven and randomized bench for the MEM stage.   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_dmem_access_stage;

   localparam int c_T = 4;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  dst;
      logic        wb;
      logic        rd;
      logic        wr;
      logic [31:0] sv;
      int          delay;
      logic [31:0] rdata;
      logic        ack_idle;
      int          exp_req;
      logic        exp_align;
      logic        exp_bus;
      logic        exp_wbwe;
      logic        chk_res;
      logic [31:0] exp_res;
   } vec_t;

   typedef struct {
      int          req;
      logic        align;
      logic        bus;
      logic        wbwe;
      logic [31:0] res;
   } obs_t;

   logic        Clk = 1'b0;
   logic        Reset;
   logic [31:0] ExResult;
   logic [4:0]  ExDst;
   logic        ExWriteBack;
   logic [31:0] ExStoreVal;
   logic        ExMemRead;
   logic        ExMemWrite;
   logic        Stall;
   logic [31:0] WbResult;
   logic [4:0]  WbDst;
   logic        WbWriteBack;
   logic        AlignErr;
   logic        BusErr;

   int n_cmp = 0;
   int n_err = 0;

   dmem_access_stage_if mem ();

   dmem_access_stage #(
      .TIMEOUT_CYCLES (c_T),
      .CNT_W          (3)
   ) dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .ExResult    (ExResult),
      .ExDst       (ExDst),
      .ExWriteBack (ExWriteBack),
      .ExStoreVal  (ExStoreVal),
      .ExMemRead   (ExMemRead),
      .ExMemWrite  (ExMemWrite),
      .Stall       (Stall),
      .mem         (mem),
      .WbResult    (WbResult),
      .WbDst       (WbDst),
      .WbWriteBack (WbWriteBack),
      .AlignErr    (AlignErr),
      .BusErr      (BusErr)
   );

   always #5 Clk = ~Clk;

   task automatic chk1(input string nm, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b, expected %b (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic [31:0] res, input logic [4:0] dst, input logic wb,
                               input logic rd, input logic wr, input logic [31:0] sv,
                               input int delay, input logic [31:0] rdata, input logic ack_idle,
                               input int exp_req, input logic exp_align, input logic exp_bus,
                               input logic exp_wbwe, input logic chk_res, input logic [31:0] exp_res);
      vec_t v;
      v.res = res; v.dst = dst; v.wb = wb; v.rd = rd; v.wr = wr; v.sv = sv;
      v.delay = delay; v.rdata = rdata; v.ack_idle = ack_idle;
      v.exp_req = exp_req; v.exp_align = exp_align; v.exp_bus = exp_bus;
      v.exp_wbwe = exp_wbwe; v.chk_res = chk_res; v.exp_res = exp_res;
      return v;
   endfunction

   task automatic chk_all_zero(input string tag);
      chk32({tag, "_wbres"}, WbResult, 32'h0);
      chk32({tag, "_wbdst"}, 32'(WbDst), 32'h0);
      chk1({tag, "_wbwe"}, WbWriteBack, 1'b0);
      chk1({tag, "_align"}, AlignErr, 1'b0);
      chk1({tag, "_bus"}, BusErr, 1'b0);
      chk32({tag, "_addr"}, mem.MemAddr, 32'h0);
      chk32({tag, "_wdata"}, mem.MemWData, 32'h0);
      chk1({tag, "_we"}, mem.MemWe, 1'b0);
      chk1({tag, "_req"}, mem.MemReq, 1'b0);
      chk1({tag, "_stall"}, Stall, 1'b0);
   endtask

   // Called just after a rising edge; returns just after a rising edge.
   // Expectations follow the stage rules: an aligned memory op holds the request
   // for (delay+1) cycles if the ack lands inside the timeout window, else c_T cycles.
   task automatic run_op(input vec_t v, output obs_t o);
      logic memop, aligned, last;
      int   n_exp;
      memop   = v.rd | v.wr;
      aligned = (v.res[1:0] == 2'b00);
      o.req = 0; o.align = 1'b0; o.bus = 1'b0; o.wbwe = 1'b0; o.res = '0;
      ExResult = v.res; ExDst = v.dst; ExWriteBack = v.wb;
      ExMemRead = v.rd; ExMemWrite = v.wr; ExStoreVal = v.sv;
      mem.MemAck = v.ack_idle; mem.MemRData = $urandom;
      @(negedge Clk);
      chk1("req_in_idle", mem.MemReq, 1'b0);
      chk1("stall_first", Stall, memop && aligned);
      @(posedge Clk); #1;
      mem.MemAck = 1'b0;
      o.align = AlignErr;
      o.bus   = BusErr;
      chk1("align_err", AlignErr, memop && !aligned);
      chk1("bus_err_first", BusErr, 1'b0);
      if (!memop) begin
         chk32("alu_res", WbResult, v.res);
         chk32("alu_dst", 32'(WbDst), 32'(v.dst));
         chk1("alu_we", WbWriteBack, v.wb && (v.dst != 5'd0));
      end else begin
         chk1("bubble_we", WbWriteBack, 1'b0);
      end
      if (memop && aligned) begin
         n_exp = (v.delay < c_T) ? v.delay + 1 : c_T;
         for (int i = 0; i < 20; i++) begin
            mem.MemAck   = (i == v.delay);
            mem.MemRData = (i == v.delay) ? v.rdata : $urandom;
            @(negedge Clk);
            if (!mem.MemReq) begin
               chk1("req_early_drop", mem.MemReq, 1'b1);
               break;
            end
            o.req++;
            chk32("mem_addr", mem.MemAddr, v.res);
            chk1("mem_we", mem.MemWe, v.wr);
            chk32("mem_wdata", mem.MemWData, v.sv);
            last = (i == v.delay) || (i == c_T - 1);
            chk1("stall_wait", Stall, !last);
            @(posedge Clk); #1;
            mem.MemAck = 1'b0;
            if (last) begin
               o.bus = BusErr;
               if (i == v.delay) begin
                  chk1("bus_err_ack", BusErr, 1'b0);
                  if (!v.wr) begin
                     chk32("load_res", WbResult, v.rdata);
                     chk32("load_dst", 32'(WbDst), 32'(v.dst));
                     chk1("load_we", WbWriteBack, v.wb && (v.dst != 5'd0));
                  end else begin
                     chk1("store_we", WbWriteBack, 1'b0);
                  end
               end else begin
                  chk1("bus_err_expire", BusErr, 1'b1);
                  chk1("expire_we", WbWriteBack, 1'b0);
               end
               chk1("req_released", mem.MemReq, 1'b0);
               break;
            end else begin
               chk1("wait_we", WbWriteBack, 1'b0);
               chk1("wait_bus_err", BusErr, 1'b0);
            end
         end
         chk32("req_cycles", 32'(o.req), 32'(n_exp));
      end
      o.wbwe = WbWriteBack;
      o.res  = WbResult;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[13];
      vec_t rv;
      obs_t o;
      int   kind;

      Reset = 1'b0;
      ExResult = '0; ExDst = '0; ExWriteBack = 1'b0; ExStoreVal = '0;
      ExMemRead = 1'b0; ExMemWrite = 1'b0;
      mem.MemAck = 1'b0; mem.MemRData = '0;

      //                res           dst wb rd wr sv            dly rdata         ai req al bu we cr exp_res
      tbl[0]  = mk(32'h0000_1234, 5,  1, 0, 0, 32'h0,        0,  32'h0,        0, 0, 0, 0, 1, 1, 32'h0000_1234);
      tbl[1]  = mk(32'hA5A5_0001, 0,  1, 0, 0, 32'h0,        0,  32'h0,        0, 0, 0, 0, 0, 1, 32'hA5A5_0001);
      tbl[2]  = mk(32'h0000_0007, 31, 0, 0, 0, 32'h0,        0,  32'h0,        1, 0, 0, 0, 0, 1, 32'h0000_0007);
      tbl[3]  = mk(32'h0000_0102, 3,  1, 1, 0, 32'h0,        0,  32'h0,        0, 0, 1, 0, 0, 0, 32'h0);
      tbl[4]  = mk(32'h0000_0203, 3,  0, 0, 1, 32'h1111_2222, 0, 32'h0,        0, 0, 1, 0, 0, 0, 32'h0);
      tbl[5]  = mk(32'h0000_0200, 0,  0, 0, 1, 32'hDEAD_BEEF, 0, 32'h0,        0, 1, 0, 0, 0, 0, 32'h0);
      tbl[6]  = mk(32'h0000_0100, 8,  1, 1, 0, 32'h0,        3,  32'hCAFE_F00D, 0, 4, 0, 0, 1, 1, 32'hCAFE_F00D);
      tbl[7]  = mk(32'h0000_0040, 9,  1, 1, 0, 32'h0,        1,  32'h1234_5678, 0, 2, 0, 0, 1, 1, 32'h1234_5678);
      tbl[8]  = mk(32'h0000_0300, 4,  1, 1, 0, 32'h0,        99, 32'h0,        0, 4, 0, 1, 0, 0, 32'h0);
      tbl[9]  = mk(32'h0000_0055, 2,  1, 0, 0, 32'h0,        0,  32'h0,        0, 0, 0, 0, 1, 1, 32'h0000_0055);
      tbl[10] = mk(32'h0000_0080, 6,  1, 1, 1, 32'h0BAD_F00D, 2, 32'h7777_7777, 0, 3, 0, 0, 0, 0, 32'h0);
      tbl[11] = mk(32'h0000_0044, 0,  1, 1, 0, 32'h0,        0,  32'hFFFF_0000, 0, 1, 0, 0, 0, 1, 32'hFFFF_0000);
      tbl[12] = mk(32'h0000_0048, 7,  0, 1, 0, 32'h0,        3,  32'h0F0F_0F0F, 0, 4, 0, 0, 0, 1, 32'h0F0F_0F0F);

      repeat (3) @(posedge Clk);
      #1;
      chk_all_zero("reset");
      Reset = 1'b1;

      foreach (tbl[k]) begin
         run_op(tbl[k], o);
         chk32($sformatf("tbl%0d_req", k), 32'(o.req), 32'(tbl[k].exp_req));
         chk1($sformatf("tbl%0d_align", k), o.align, tbl[k].exp_align);
         chk1($sformatf("tbl%0d_bus", k), o.bus, tbl[k].exp_bus);
         chk1($sformatf("tbl%0d_wbwe", k), o.wbwe, tbl[k].exp_wbwe);
         if (tbl[k].chk_res) chk32($sformatf("tbl%0d_res", k), o.res, tbl[k].exp_res);
      end

      // Reset asserted in the middle of an outstanding load.
      ExResult = 32'h0000_0400; ExDst = 5'd12; ExWriteBack = 1'b1;
      ExMemRead = 1'b1; ExMemWrite = 1'b0; ExStoreVal = 32'h5555_AAAA;
      mem.MemAck = 1'b0;
      @(posedge Clk); #1;
      @(posedge Clk); #1;
      chk1("mid_req_before", mem.MemReq, 1'b1);
      #2;
      Reset = 1'b0;
      #1;
      chk_all_zero("mid_reset");
      ExResult = 32'h0000_0ABC; ExDst = 5'd1; ExWriteBack = 1'b1;
      ExMemRead = 1'b0;
      @(posedge Clk); #1;
      Reset = 1'b1;
      run_op(mk(32'h0000_0ABC, 1, 1, 0, 0, 32'h0, 0, 32'h0, 0, 0, 0, 0, 1, 1, 32'h0000_0ABC), o);

      for (int n = 0; n < 120; n++) begin
         kind = int'($urandom_range(0, 9));
         rv = mk($urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                 1'b0, 1'b0, $urandom, int'($urandom_range(0, 6)), $urandom,
                 1'($urandom_range(0, 1)), 0, 0, 0, 0, 0, 32'h0);
         if (kind >= 4) begin
            rv.rd = 1'($urandom_range(0, 1));
            rv.wr = ~rv.rd | 1'($urandom_range(0, 1));
            if (kind >= 6) rv.res[1:0] = 2'b00;
         end
         run_op(rv, o);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
